// File: rtl/opb_s2p_pkg.sv
// Shared constants for the Simulink-to-PPC FIFO register window:
// register offsets, STATUS/CTRL bit positions and the bus state encoding.
package opb_s2p_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_LAST   = 2'd3;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_UDF   = 19;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLEAR = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } bus_state_e;

endpackage

// File: rtl/s2p_sync_fifo.sv
// Single-clock FIFO of 32-bit samples with flush. A pop on a full FIFO frees
// the slot for a push in the same cycle; flush overrides any push.
module s2p_sync_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [31:0]        din,
    output logic [31:0]        dout,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    logic [31:0]        mem_q [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               wr_en, rd_en;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign rd_en = pop & ~empty & ~flush;
    assign wr_en = push & ~flush & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; dout is only consumed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/opb_register_simulink2ppc_fifo.sv
// OPB slave returning user-logic samples to the PPC through a FIFO, with
// STATUS, CTRL (flush / clear sticky) and LAST registers.
//
// state  | meaning
// S_IDLE | waiting for a select that hits the window
// S_ACK  | one-cycle acknowledge; read data driven, side effects applied
// S_WAIT | transfer done, holding off until select drops
module opb_register_simulink2ppc_fifo
    import opb_s2p_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h010B0100,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010B01FF,
    parameter                          C_FAMILY     = "virtex5",
    parameter int                      FIFO_AW      = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid,
    output logic                      user_full
);

    bus_state_e       state_q, state_d;
    logic [1:0]       off_q, off_d;
    logic             rnw_q, rnw_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [31:0]      last_q, last_d;

    logic [31:0]      wdata, fifo_dout, status, rdata;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             hit, ack, data_pop, pop_ok, push_ok, ctrl_wr, flush, clr;
    logic             unused_ok;

    assign wdata     = OPB_DBus;
    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata[31:2], C_FAMILY};

    assign hit      = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign ack      = (state_q == S_ACK);
    assign data_pop = ack & rnw_q & (off_q == OFF_DATA);
    assign ctrl_wr  = ack & ~rnw_q & (off_q == OFF_CTRL);
    assign flush    = ctrl_wr & ctrl_q[CTRL_FLUSH];
    assign clr      = ctrl_wr & ctrl_q[CTRL_CLEAR];
    assign pop_ok   = data_pop & ~fifo_empty;
    assign push_ok  = user_valid & ~flush & (~fifo_full | pop_ok);

    s2p_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .push  (user_valid),
        .pop   (data_pop),
        .flush (flush),
        .din   (user_data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status                = '0;
        status[FIFO_AW:0]     = fifo_count;
        status[ST_EMPTY]      = fifo_empty;
        status[ST_FULL]       = fifo_full;
        status[ST_OVF]        = ovf_q;
        status[ST_UDF]        = udf_q;
        case (off_q)
            OFF_DATA:   rdata = fifo_empty ? '0 : fifo_dout;
            OFF_STATUS: rdata = status;
            OFF_LAST:   rdata = last_q;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        rnw_d   = rnw_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (OPB_select && hit) begin
                    state_d = S_ACK;
                    off_d   = OPB_ABus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
                    rnw_d   = OPB_RNW;
                    ctrl_d  = wdata[1:0];
                end
            end
            S_ACK:   state_d = S_WAIT;
            S_WAIT:  if (!OPB_select) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A new overflow/underflow event beats a clear in the same cycle.
    always_comb begin
        ovf_d  = (clr ? 1'b0 : ovf_q) | (user_valid & ~flush & fifo_full & ~pop_ok);
        udf_d  = (clr ? 1'b0 : udf_q) | (data_pop & fifo_empty);
        last_d = push_ok ? user_data_in : last_q;
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            rnw_q   <= 1'b0;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            rnw_q   <= rnw_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            last_q  <= last_d;
        end
    end

    assign Sl_xferAck = ack;
    assign Sl_DBus    = (ack && rnw_q) ? rdata : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_full  = fifo_full;

endmodule

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
// Bench for the Simulink-to-PPC FIFO register: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a queue-based model.
module tb_opb_register_simulink2ppc_fifo;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] BASE     = 32'h010B0100;
    localparam logic [31:0] HIGH     = 32'h010B01FF;
    localparam logic [31:0] A_DATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_LAST   = BASE + 32'hC;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n = 1'b0;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = 4'hF;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b1;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;
    logic        user_full;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_simulink2ppc_fifo dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst_n    (OPB_Rst_n),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_full    (user_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents, sticky flags, last sample, bus progress.
    logic [31:0] mq[$];
    bit          m_ovf, m_udf;
    logic [31:0] m_last;
    bit          m_in_ack, m_engaged;
    logic [31:0] m_addr, m_wd;
    bit          m_rnw;

    bit          chk_en = 0;
    bit          rnd_push = 0;
    logic [31:0] last_rd;
    int          ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        case (a[3:2])
            2'd0:    r = (mq.size() != 0) ? mq[0] : 32'h0;
            2'd1:    r = {12'h0, m_udf, m_ovf, mq.size() == DEPTH, mq.size() == 0, 16'(mq.size())};
            2'd3:    r = m_last;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic tick(input bit rst, input bit v, input logic [31:0] d,
                        input bit sel, input logic [31:0] addr, input bit rnw, input logic [31:0] wd);
        logic [31:0] expv;
        bit pop, fl, cl, ovf_s, udf_s, new_ack;
        if (chk_en) begin
            expv = (m_in_ack && m_rnw) ? model_read(m_addr) : 32'h0;
            chk("xferack", {31'h0, Sl_xferAck}, {31'h0, m_in_ack});
            chk("sl_dbus", Sl_DBus, expv);
            chk("user_full", {31'h0, user_full}, {31'h0, mq.size() == DEPTH});
        end
        if (Sl_xferAck === 1'b1) begin
            last_rd = Sl_DBus;
            ack_cnt++;
        end
        OPB_Rst_n    = !rst;
        user_valid   = v;
        user_data_in = d;
        OPB_select   = sel;
        OPB_ABus     = addr;
        OPB_RNW      = rnw;
        OPB_DBus     = wd;
        @(posedge OPB_Clk);
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_last = '0;
            m_in_ack = 0; m_engaged = 0;
        end else begin
            pop = 0; fl = 0; cl = 0; ovf_s = 0; udf_s = 0;
            if (m_in_ack) begin
                if (m_rnw && m_addr[3:2] == 2'd0) pop = 1;
                if (!m_rnw && m_addr[3:2] == 2'd2) begin
                    fl = m_wd[0];
                    cl = m_wd[1];
                end
            end
            if (fl) mq.delete();
            else begin
                if (pop) begin
                    if (mq.size() == 0) udf_s = 1;
                    else void'(mq.pop_front());
                end
                if (v) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(d);
                        m_last = d;
                    end else ovf_s = 1;
                end
            end
            if (cl) begin m_ovf = 0; m_udf = 0; end
            m_ovf = m_ovf | ovf_s;
            m_udf = m_udf | udf_s;
            new_ack = !m_in_ack && !m_engaged && sel && model_hit(addr);
            if (m_in_ack) m_engaged = 1;
            else if (m_engaged && !sel) m_engaged = 0;
            if (new_ack) begin m_addr = addr; m_rnw = rnw; m_wd = wd; end
            m_in_ack = new_ack;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(0, rnd_push && ($urandom_range(0, 3) != 0), $urandom, 0, 32'h0, 1, 32'h0);
    endtask

    task automatic push(input logic [31:0] d);
        tick(0, 1, d, 0, 32'h0, 1, 32'h0);
    endtask

    // Select is held through the ack cycle, plus 'hold' extra cycles.
    task automatic bus(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                       input bit v1, input bit v2, input int hold);
        tick(0, v1, $urandom, 1, addr, rnw, wd);
        tick(0, v2, $urandom, 1, addr, rnw, wd);
        for (int i = 0; i < hold; i++)
            tick(0, rnd_push && ($urandom_range(0, 1) == 1), $urandom, 1, addr, rnw, wd);
        tick(0, 0, 32'h0, 0, 32'h0, 1, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr);
        bus(addr, 1, 32'h0, 0, 0, 0);
    endtask

    int          acks0;
    logic [31:0] addr_r, wd_r;

    initial begin
        tick(1, 0, 32'h0, 0, 32'h0, 1, 32'h0);
        chk_en = 1;
        tick(1, 0, 32'h0, 0, 32'h0, 1, 32'h0);
        idle(2);

        rd(A_STATUS);
        chk("reset_status", last_rd, 32'h00010000);
        rd(A_LAST);
        chk("reset_last", last_rd, 32'h0);

        push(32'hA5A50001); push(32'hA5A50002); push(32'hA5A50003);
        rd(A_STATUS);
        chk("status_cnt3", last_rd, 32'h00000003);
        rd(A_LAST);
        chk("last_3", last_rd, 32'hA5A50003);
        for (int i = 1; i <= 3; i++) begin
            rd(A_DATA);
            chk("data_order", last_rd, 32'hA5A50000 + 32'(i));
        end
        rd(A_STATUS);
        chk("status_drained", last_rd, 32'h00010000);

        for (int i = 1; i <= 17; i++) push(32'h1000 + 32'(i));
        chk("user_full_17", {31'h0, user_full}, 32'h1);
        rd(A_STATUS);
        chk("status_full_ovf", last_rd, 32'h00060010);
        rd(A_LAST);
        chk("last_not_dropped", last_rd, 32'h00001010);
        for (int i = 1; i <= 16; i++) begin
            rd(A_DATA);
            chk("data_full_order", last_rd, 32'h1000 + 32'(i));
        end

        rd(A_DATA);
        chk("data_empty", last_rd, 32'h0);
        rd(A_STATUS);
        chk("status_udf", last_rd, 32'h000D0000);
        bus(A_CTRL, 0, 32'h2, 0, 0, 0);
        rd(A_STATUS);
        chk("status_cleared", last_rd, 32'h00010000);

        acks0 = ack_cnt;
        bus(A_STATUS, 1, 32'h0, 0, 0, 3);
        chk("held_sel_one_ack", 32'(ack_cnt - acks0), 32'd1);
        acks0 = ack_cnt;
        bus(32'h010B0200, 1, 32'h0, 0, 0, 3);
        bus(BASE - 32'h4, 1, 32'h0, 0, 0, 0);
        chk("miss_no_ack", 32'(ack_cnt - acks0), 32'd0);

        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i));
        bus(A_DATA, 1, 32'h0, 0, 1, 0);
        chk("pop_push_data", last_rd, 32'h2000);
        rd(A_STATUS);
        chk("pop_push_cnt4", last_rd, 32'h00000004);
        bus(A_CTRL, 0, 32'h1, 0, 1, 0);
        rd(A_STATUS);
        chk("flush_push", last_rd, 32'h00010000);

        for (int i = 0; i < 16; i++) push(32'h3000 + 32'(i));
        bus(A_DATA, 1, 32'h0, 0, 1, 0);
        rd(A_STATUS);
        chk("full_pop_push", last_rd, 32'h00020010);
        bus(A_CTRL, 0, 32'h1, 0, 0, 0);
        bus(A_DATA, 1, 32'h0, 0, 1, 0);
        chk("empty_pop_push_data", last_rd, 32'h0);
        rd(A_STATUS);
        chk("empty_pop_push_st", last_rd, 32'h00080001);
        bus(A_CTRL, 0, 32'h3, 0, 0, 0);

        push(32'h4444);
        acks0 = ack_cnt;
        tick(0, 0, 32'h0, 1, A_STATUS, 1, 32'h0);
        tick(0, 0, 32'h0, 1, A_STATUS, 1, 32'h0);
        tick(1, 0, 32'h0, 1, A_STATUS, 1, 32'h0);
        idle(3);
        chk("reset_wait_acks", 32'(ack_cnt - acks0), 32'd1);
        rd(A_STATUS);
        chk("reset_wait_status", last_rd, 32'h00010000);

        rnd_push = 1;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3: idle($urandom_range(1, 4));
                4, 5: for (int j = 0; j < $urandom_range(2, 12); j++) push($urandom);
                6: tick(1, 0, 32'h0, 0, 32'h0, 1, 32'h0);
                default: begin
                    if ($urandom_range(0, 9) == 0)
                        addr_r = ($urandom_range(0, 1) == 1) ? HIGH + 32'h4 : BASE - 32'h100;
                    else
                        addr_r = BASE + {$urandom_range(0, 63), 2'b00};
                    wd_r = ($urandom_range(0, 5) == 0) ? $urandom : {$urandom_range(0, 0), 1'b0, 1'b1} & 32'h0;
                    if ($urandom_range(0, 3) == 0) wd_r = {30'h0, 1'b1, 1'b0};
                    bus(addr_r, $urandom_range(0, 3) != 0, wd_r,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
                end
            endcase
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
